// File: rtl/config_reg_bank.sv
// Bank of NUM_REGS wide config registers on the shared GPIO write bus.
// Byte writes build up staging words; live words load on commit or on word completion.
module config_reg_bank #(
    parameter int                              DATA_W      = 8,
    parameter int                              NUM_BYTES   = 4,
    parameter int                              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]               BASE_ADDR   = 16'h0000,
    parameter int                              NUM_REGS    = 4,
    parameter bit                              AUTO_COMMIT = 1'b0,
    parameter logic [DATA_W*NUM_BYTES-1:0]     RESET_VAL   = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [31:0]                        gpio_in,
    output logic [NUM_REGS*DATA_W*NUM_BYTES-1:0] reg_out,
    output logic [NUM_REGS-1:0]                upd_o,
    output logic [DATA_W*NUM_BYTES-1:0]        rd_data_o,
    output logic                               rd_valid_o
);

    localparam int REG_W = DATA_W * NUM_BYTES;
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TOP   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] CMT_ADDR = ADDR_W'(BASE_ADDR + NUM_REGS);

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_wclk;
    logic              w_we;
    logic [ADDR_W-1:0] w_off;
    logic              w_reg_hit;
    logic              w_cmt_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [REG_W-1:0]  w_shifted;
    logic              w_word_done;

    logic [2:0]        r_sync;
    logic [REG_W-1:0]  r_staging [NUM_REGS];
    logic [REG_W-1:0]  r_live    [NUM_REGS];
    logic [CNT_W-1:0]  r_cnt     [NUM_REGS];
    logic [NUM_REGS-1:0] r_upd;
    logic [REG_W-1:0]  r_rd_data;
    logic              r_rd_valid;

    assign w_addr = gpio_in[ADDR_W-1:0];
    assign w_data = gpio_in[TOP-1:ADDR_W];
    assign w_wclk = gpio_in[TOP];

    generate
        if (TOP + 1 < 32) begin : g_spare
            logic w_unused;
            assign w_unused = ^gpio_in[31:TOP+1];
        end
    endgenerate

    // w_clk is asynchronous to clk; one write per rising edge however long it stays high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], w_wclk};
        end
    end

    assign w_we        = r_sync[1] & ~r_sync[2];
    assign w_off       = w_addr - BASE_ADDR;
    assign w_reg_hit   = (w_off < ADDR_W'(NUM_REGS));
    assign w_cmt_hit   = (w_addr == CMT_ADDR);
    assign w_idx       = w_off[IDX_W-1:0];
    assign w_shifted   = REG_W'({r_staging[w_idx], w_data});
    assign w_word_done = (r_cnt[w_idx] == CNT_W'(NUM_BYTES - 1));

    // Write path: staging shift, byte counting, commit/clear and auto-commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_staging[k] <= '0;
                r_live[k]    <= RESET_VAL;
                r_cnt[k]     <= '0;
            end
            r_upd <= '0;
        end else begin
            r_upd <= '0;
            if (w_we && w_reg_hit) begin
                r_staging[w_idx] <= w_shifted;
                if (w_word_done) begin
                    r_cnt[w_idx] <= '0;
                    if (AUTO_COMMIT) begin
                        r_live[w_idx] <= w_shifted;
                        r_upd[w_idx]  <= 1'b1;
                    end
                end else begin
                    r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
                end
            end else if (w_we && w_cmt_hit) begin
                // Commit reads staging before the clear below takes effect
                if (w_data[0]) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        r_live[k] <= r_staging[k];
                    end
                    r_upd <= '1;
                end
                if (w_data[1]) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        r_staging[k] <= '0;
                        r_cnt[k]     <= '0;
                    end
                end
            end
        end
    end

    // Readback follows the current bus address every cycle, one cycle late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_reg_hit) begin
            r_rd_data  <= r_live[w_idx];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
            assign reg_out[i*REG_W +: REG_W] = r_live[i];
        end
    endgenerate

    assign upd_o      = r_upd;
    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;

endmodule

// File: tb/tb_config_reg_bank.sv
// Directed bench for config_reg_bank: one manual-commit bank and one auto-commit bank,
// each on its own GPIO bus, base address 0x0010, four 32-bit registers.
module tb_config_reg_bank;

    logic         clk;
    logic         rst;
    logic [31:0]  gm;
    logic [31:0]  ga;
    logic [127:0] reg_out_m, reg_out_a;
    logic [3:0]   upd_m, upd_a;
    logic [31:0]  rd_data_m, rd_data_a;
    logic         rd_valid_m, rd_valid_a;

    int n_checks = 0;
    int n_fail   = 0;

    int upd_cyc_m = 0, run_m = 0, max_run_m = 0;
    int upd_cyc_a = 0, run_a = 0, max_run_a = 0;
    logic [3:0] last_upd_a = '0;

    config_reg_bank #(.DATA_W(8), .NUM_BYTES(4), .ADDR_W(16), .BASE_ADDR(16'h0010),
                      .NUM_REGS(4), .AUTO_COMMIT(1'b0), .RESET_VAL(32'h0)) dut_m (
        .clk(clk), .rst(rst), .gpio_in(gm), .reg_out(reg_out_m), .upd_o(upd_m),
        .rd_data_o(rd_data_m), .rd_valid_o(rd_valid_m));

    config_reg_bank #(.DATA_W(8), .NUM_BYTES(4), .ADDR_W(16), .BASE_ADDR(16'h0010),
                      .NUM_REGS(4), .AUTO_COMMIT(1'b1), .RESET_VAL(32'h0)) dut_a (
        .clk(clk), .rst(rst), .gpio_in(ga), .reg_out(reg_out_a), .upd_o(upd_a),
        .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd_m != 4'b0) begin
            upd_cyc_m++;
            run_m++;
            if (run_m > max_run_m) max_run_m = run_m;
        end else begin
            run_m = 0;
        end
        if (upd_a != 4'b0) begin
            upd_cyc_a++;
            run_a++;
            last_upd_a = upd_a;
            if (run_a > max_run_a) max_run_a = run_a;
        end else begin
            run_a = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus(input logic wclk, input logic [15:0] a, input logic [7:0] d);
        return {7'b0, wclk, d, a};
    endfunction

    // One GPIO write: w_clk high for 'hold' cycles, then low long enough to re-arm the edge detector
    task automatic wr(input bit to_auto, input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        if (to_auto) ga = bus(1'b1, a, d); else gm = bus(1'b1, a, d);
        repeat (hold) @(negedge clk);
        if (to_auto) ga = bus(1'b0, a, d); else gm = bus(1'b0, a, d);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        gm  = '0;
        ga  = '0;
        repeat (2) @(negedge clk);
        chk("reset_reg_out_m", reg_out_m, 128'h0);
        chk("reset_upd_m", {124'h0, upd_m}, 128'h0);
        chk("reset_rd_valid_m", {127'h0, rd_valid_m}, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // Manual mode: four bytes to reg 2, then commit with exact pulse timing
        wr(1'b0, 16'h0012, 8'hDE, 4);
        wr(1'b0, 16'h0012, 8'hAD, 4);
        wr(1'b0, 16'h0012, 8'hBE, 4);
        wr(1'b0, 16'h0012, 8'hEF, 4);
        chk("no_live_before_commit", reg_out_m, 128'h0);
        chk("no_upd_before_commit", upd_cyc_m, 0);
        @(negedge clk);
        gm = bus(1'b1, 16'h0014, 8'h01);
        @(negedge clk);
        chk("commit_upd_edge1", {124'h0, upd_m}, 128'h0);
        @(negedge clk);
        chk("commit_upd_edge2", {124'h0, upd_m}, 128'h0);
        @(negedge clk);
        chk("commit_upd_edge3", {124'h0, upd_m}, {124'h0, 4'b1111});
        chk("commit_reg_out", reg_out_m, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
        @(negedge clk);
        chk("commit_upd_edge4", {124'h0, upd_m}, 128'h0);
        gm = bus(1'b0, 16'h0014, 8'h01);
        repeat (4) @(negedge clk);
        chk("commit_single_pulse", upd_cyc_m, 1);

        // Readback, one cycle after the address is presented
        gm = bus(1'b0, 16'h0012, 8'h00);
        @(negedge clk);
        chk("rd_data_reg2", rd_data_m, 32'hDEADBEEF);
        chk("rd_valid_reg2", rd_valid_m, 1'b1);

        // Stage reg 1 without commit, then commit+clear, then commit again
        upd_cyc_m = 0;
        wr(1'b0, 16'h0011, 8'h12, 4);
        wr(1'b0, 16'h0011, 8'h34, 4);
        wr(1'b0, 16'h0011, 8'h56, 4);
        wr(1'b0, 16'h0011, 8'h78, 4);
        chk("stage_only_reg_out", reg_out_m, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
        chk("stage_only_no_upd", upd_cyc_m, 0);
        wr(1'b0, 16'h0014, 8'h03, 4);
        chk("commit_clear_reg_out", reg_out_m, {32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0});
        wr(1'b0, 16'h0014, 8'h01, 4);
        chk("commit_after_clear", reg_out_m, 128'h0);
        chk("two_commit_pulses", upd_cyc_m, 2);

        // Out-of-range address: no state change, readback invalid
        wr(1'b0, 16'h0020, 8'h77, 4);
        wr(1'b0, 16'h0014, 8'h01, 4);
        chk("oor_write_ignored", reg_out_m, 128'h0);
        gm = bus(1'b0, 16'h0020, 8'h00);
        @(negedge clk);
        chk("oor_rd_valid", rd_valid_m, 1'b0);
        chk("oor_rd_data", rd_data_m, 32'h0);

        // w_clk held high for 100 cycles gives one shift only
        upd_cyc_m = 0;
        wr(1'b0, 16'h0010, 8'hAA, 100);
        chk("held_no_upd_manual", upd_cyc_m, 0);
        wr(1'b0, 16'h0014, 8'h01, 4);
        chk("held_one_shift", reg_out_m, {96'h0, 32'h000000AA});

        // Auto-commit: update only on the 4th byte
        wr(1'b1, 16'h0010, 8'h01, 4);
        wr(1'b1, 16'h0010, 8'h02, 4);
        wr(1'b1, 16'h0010, 8'h03, 4);
        chk("auto_partial_no_upd", upd_cyc_a, 0);
        chk("auto_partial_reg", reg_out_a, 128'h0);
        wr(1'b1, 16'h0010, 8'h04, 4);
        chk("auto_word_reg", reg_out_a, {96'h0, 32'h01020304});
        chk("auto_word_upd_count", upd_cyc_a, 1);
        chk("auto_word_upd_mask", {124'h0, last_upd_a}, {124'h0, 4'b0001});
        wr(1'b1, 16'h0010, 8'h05, 4);
        chk("auto_5th_no_upd", upd_cyc_a, 1);
        chk("auto_5th_reg", reg_out_a, {96'h0, 32'h01020304});

        // Auto-commit: clear, held byte counts once, word completes after three more
        wr(1'b1, 16'h0014, 8'h02, 4);
        wr(1'b1, 16'h0010, 8'hAA, 100);
        wr(1'b1, 16'h0010, 8'h0B, 4);
        wr(1'b1, 16'h0010, 8'h0C, 4);
        chk("auto_held_cnt_pending", upd_cyc_a, 1);
        wr(1'b1, 16'h0010, 8'h0D, 4);
        chk("auto_held_cnt_word", reg_out_a, {96'h0, 32'hAA0B0C0D});
        chk("auto_held_upd_count", upd_cyc_a, 2);
        chk("max_run_m", max_run_m, 1);
        chk("max_run_a", max_run_a, 1);

        // Asynchronous reset mid-word
        wr(1'b0, 16'h0013, 8'h11, 4);
        wr(1'b0, 16'h0013, 8'h22, 4);
        gm = bus(1'b0, 16'h0010, 8'h00);
        @(negedge clk);
        chk("pre_reset_rd_valid", rd_valid_m, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_reg_out_m", reg_out_m, 128'h0);
        chk("async_reset_reg_out_a", reg_out_a, 128'h0);
        chk("async_reset_rd_valid", rd_valid_m, 1'b0);
        chk("async_reset_rd_data", rd_data_m, 32'h0);
        chk("async_reset_upd", {124'h0, upd_m}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        gm  = '0;
        @(negedge clk);
        wr(1'b0, 16'h0014, 8'h01, 4);
        chk("staging_cleared_by_reset", reg_out_m, 128'h0);
        wr(1'b0, 16'h0013, 8'h55, 4);
        wr(1'b0, 16'h0013, 8'h66, 4);
        wr(1'b0, 16'h0013, 8'h77, 4);
        wr(1'b0, 16'h0013, 8'h88, 4);
        wr(1'b0, 16'h0014, 8'h01, 4);
        chk("post_reset_reg3", reg_out_m, {32'h55667788, 96'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
